// File: rtl/dm_cache_data_array.sv
// dm_cache_data_array
//   Data array of the direct-mapped cache. It stores one line of
//   WORDS_PER_LINE words per index. After reset an internal sweep writes
//   zero to every line. All traffic is dropped until the sweep finishes.
//
// Ports
//   clk, rst     : single clock; asynchronous active-high reset
//   init_busy    : high while the zeroing sweep runs
//   rd_req       : read request (sampled only when ready)
//   rd_index     : line index to read
//   rd_valid     : rd_line carries a read result this cycle
//   rd_line      : registered read data; holds its value between reads
//   wr_en        : CPU word write
//   wr_index     : line index of the CPU write
//   wr_word_sel  : word within the line (ignored when WORDS_PER_LINE == 1)
//   wr_byte_en   : per-byte enables of the CPU write
//   wr_data      : CPU write data
//   fill_en      : full-line refill from the miss handler
//   fill_index   : line index of the refill
//   fill_line    : refill data
module dm_cache_data_array #(
   parameter  int INDEX_W        = 10,
   parameter  int WORDS_PER_LINE = 4,
   parameter  int WORD_W         = 32,
   localparam int LINE_W         = WORD_W * WORDS_PER_LINE,
   localparam int SEL_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
   localparam int BE_W           = WORD_W / 8
) (
   input  logic               clk,
   input  logic               rst,
   output logic               init_busy,
   input  logic               rd_req,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [LINE_W-1:0]  rd_line,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [SEL_W-1:0]   wr_word_sel,
   input  logic [BE_W-1:0]    wr_byte_en,
   input  logic [WORD_W-1:0]  wr_data,
   input  logic               fill_en,
   input  logic [INDEX_W-1:0] fill_index,
   input  logic [LINE_W-1:0]  fill_line
);

   localparam int DEPTH = 2 ** INDEX_W;
   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

   typedef enum logic {
      INIT,
      READY
   } state_t;

   state_t              state;
   logic [INDEX_W-1:0]  sweep_idx;
   logic [LINE_W-1:0]   mem [DEPTH];

   logic                fill_go;
   logic                cpu_go;
   logic [LINE_W-1:0]   cpu_line;
   logic [LINE_W-1:0]   rd_next;

   // Traffic is only honoured once the sweep has completed.
   assign fill_go = (state == READY) && fill_en;
   assign cpu_go  = (state == READY) && wr_en;

   // Line written by the CPU port. When a refill hits the same index in the
   // same cycle, the refill data is the base and the CPU bytes are overlaid.
   always_comb begin
      cpu_line = (fill_go && (fill_index == wr_index)) ? fill_line : mem[wr_index];
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (((WORDS_PER_LINE == 1) || (wr_word_sel == SEL_W'(w))) && wr_byte_en[b]) begin
               cpu_line[w*WORD_W + b*8 +: 8] = wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Write-first read: the CPU line already contains any same-index refill,
   // so it takes priority over the bare refill data.
   always_comb begin
      if (cpu_go && (wr_index == rd_index)) begin
         rd_next = cpu_line;
      end else if (fill_go && (fill_index == rd_index)) begin
         rd_next = fill_line;
      end else begin
         rd_next = mem[rd_index];
      end
   end

   // Storage. On a same-index fill and CPU write the CPU assignment comes
   // last, and cpu_line already carries the merged line.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[sweep_idx] <= '0;
      end else begin
         if (fill_go) begin
            mem[fill_index] <= fill_line;
         end
         if (cpu_go) begin
            mem[wr_index] <= cpu_line;
         end
      end
   end

   // Control FSM with registered outputs. The sweep counter stops on the
   // terminal compare, so it never wraps back into INIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         sweep_idx <= '0;
         init_busy <= 1'b1;
         rd_valid  <= 1'b0;
         rd_line   <= '0;
      end else begin
         case (state)
            INIT: begin
               rd_valid <= 1'b0;
               if (sweep_idx == LAST_IDX) begin
                  state     <= READY;
                  init_busy <= 1'b0;
               end else begin
                  sweep_idx <= sweep_idx + INDEX_W'(1);
               end
            end
            READY: begin
               rd_valid <= rd_req;
               if (rd_req) begin
                  rd_line <= rd_next;
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_data_array.sv
module tb_dm_cache_data_array;

   localparam int IW    = 4;
   localparam int WPL   = 4;
   localparam int WW    = 32;
   localparam int LW    = WW * WPL;
   localparam int SW    = 2;
   localparam int BW    = WW / 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_busy;
   logic          rd_req;
   logic [IW-1:0] rd_index;
   logic          rd_valid;
   logic [LW-1:0] rd_line;
   logic          wr_en;
   logic [IW-1:0] wr_index;
   logic [SW-1:0] wr_word_sel;
   logic [BW-1:0] wr_byte_en;
   logic [WW-1:0] wr_data;
   logic          fill_en;
   logic [IW-1:0] fill_index;
   logic [LW-1:0] fill_line;

   dm_cache_data_array #(
      .INDEX_W        (IW),
      .WORDS_PER_LINE (WPL),
      .WORD_W         (WW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .init_busy   (init_busy),
      .rd_req      (rd_req),
      .rd_index    (rd_index),
      .rd_valid    (rd_valid),
      .rd_line     (rd_line),
      .wr_en       (wr_en),
      .wr_index    (wr_index),
      .wr_word_sel (wr_word_sel),
      .wr_byte_en  (wr_byte_en),
      .wr_data     (wr_data),
      .fill_en     (fill_en),
      .fill_index  (fill_index),
      .fill_line   (fill_line)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Behavioural model: a plain array of lines plus a count of sweep edges.
   logic [LW-1:0] m [DEPTH];
   int            sweep;
   logic          exp_busy;
   logic          exp_valid;
   logic [LW-1:0] exp_line;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      sweep     = 0;
      exp_busy  = 1'b1;
      exp_valid = 1'b0;
      exp_line  = '0;
   endtask

   // Called just after each rising edge with the inputs that edge sampled.
   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (sweep < DEPTH) begin
         sweep++;
         exp_valid = 1'b0;
         if (sweep == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) m[i] = '0;
            exp_busy = 1'b0;
         end
      end else begin
         if (fill_en) m[fill_index] = fill_line;
         if (wr_en) begin
            for (int b = 0; b < BW; b++) begin
               if (wr_byte_en[b]) m[wr_index][int'(wr_word_sel)*WW + b*8 +: 8] = wr_data[b*8 +: 8];
            end
         end
         exp_valid = rd_req;
         if (rd_req) exp_line = m[rd_index];
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("init_busy", LW'(init_busy), LW'(exp_busy));
      check("rd_valid", LW'(rd_valid), LW'(exp_valid));
      check("rd_line", rd_line, exp_line);
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      rd_req  = 1'b0;
      wr_en   = 1'b0;
      fill_en = 1'b0;
   endtask

   task automatic rand_in();
      rd_req      = 1'($urandom_range(0, 1));
      rd_index    = IW'($urandom_range(0, DEPTH - 1));
      wr_en       = 1'($urandom_range(0, 1));
      wr_index    = IW'($urandom_range(0, DEPTH - 1));
      wr_word_sel = SW'($urandom_range(0, WPL - 1));
      wr_byte_en  = BW'($urandom_range(0, 15));
      wr_data     = $urandom;
      fill_en     = ($urandom_range(0, 3) == 0);
      fill_index  = IW'($urandom_range(0, DEPTH - 1));
      fill_line   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Asserts rst between edges and checks the outputs respond at once.
   task automatic reset_mid_cycle(input string name);
      @(posedge clk);
      model_edge();
      #2 rst = 1'b1;
      model_reset();
      #1;
      check({name, "_busy"}, LW'(init_busy), LW'(1'b1));
      check({name, "_valid"}, LW'(rd_valid), LW'(1'b0));
      check({name, "_line"}, rd_line, '0);
      @(negedge clk);
      idle();
      step();
      rst = 1'b0;
   endtask

   task automatic count_sweep(input string name, input bit random_traffic);
      int busy_cnt = 0;
      repeat (40) begin
         if (init_busy) begin
            busy_cnt++;
            if (random_traffic) rand_in();
            else idle();
         end else begin
            idle();
         end
         step();
      end
      check(name, LW'(busy_cnt), LW'(16));
   endtask

   task automatic read_all(input string name, input bit expect_zero);
      int vcnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_req   = 1'b1;
         rd_index = IW'(i);
         step();
         if (rd_valid) vcnt++;
         if (expect_zero) check({name, "_zero"}, rd_line, '0);
      end
      idle();
      step();
      check({name, "_valid_run"}, LW'(vcnt), LW'(16));
   endtask

   initial begin
      rst = 1'b1;
      idle();
      rd_index    = '0;
      wr_index    = '0;
      wr_word_sel = '0;
      wr_byte_en  = '0;
      wr_data     = '0;
      fill_index  = '0;
      fill_line   = '0;
      model_reset();
      repeat (3) step();
      check("reset_busy", LW'(init_busy), LW'(1'b1));
      check("reset_valid", LW'(rd_valid), LW'(1'b0));
      check("reset_line", rd_line, '0);

      // Sweep with traffic attempted throughout INIT; all of it must be dropped.
      rst = 1'b0;
      count_sweep("sweep_cycles", 1'b1);
      read_all("post_init", 1'b1);

      // Refill then byte-enabled CPU write of word 1.
      fill_en    = 1'b1;
      fill_index = IW'(5);
      fill_line  = 128'h44444444_33333333_22222222_11111111;
      step();
      idle();
      wr_en       = 1'b1;
      wr_index    = IW'(5);
      wr_word_sel = SW'(1);
      wr_byte_en  = 4'b0101;
      wr_data     = 32'hAABBCCDD;
      step();
      idle();
      rd_req   = 1'b1;
      rd_index = IW'(5);
      step();
      idle();
      check("byte_merge_line", rd_line, 128'h44444444_33333333_22BB22DD_11111111);
      check("byte_merge_model", m[5], 128'h44444444_33333333_22BB22DD_11111111);

      // Same-cycle refill, CPU write and read of index 7.
      fill_en     = 1'b1;
      fill_index  = IW'(7);
      fill_line   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
      wr_en       = 1'b1;
      wr_index    = IW'(7);
      wr_word_sel = SW'(2);
      wr_byte_en  = 4'b1001;
      wr_data     = 32'h12345678;
      rd_req      = 1'b1;
      rd_index    = IW'(7);
      step();
      idle();
      check("fill_cpu_same_idx", rd_line, 128'hDDDDDDDD_12CCCC78_BBBBBBBB_AAAAAAAA);
      check("fill_cpu_valid", LW'(rd_valid), LW'(1'b1));

      // Randomised traffic against the model.
      repeat (400) begin
         rand_in();
         step();
      end
      idle();
      step();
      read_all("post_random", 1'b0);

      // Reset in the middle of a read, then again partway through the sweep.
      rd_req   = 1'b1;
      rd_index = IW'(7);
      reset_mid_cycle("rst_mid_read");
      repeat (8) step();
      reset_mid_cycle("rst_mid_sweep");
      count_sweep("resweep_cycles", 1'b0);
      read_all("post_resweep", 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
